// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encodings and baud divider helper
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_START   = ST_START,
        S_DATA    = ST_DATA,
        S_STOP    = ST_STOP,
        S_RECOVER = ST_RECOVER
    } rx_state_e;

    // Clock cycles per serial bit; shared with the transmitter so both ends agree.
    function automatic int clks_per_bit(input int clk_hz, input int baud_rate);
        return clk_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready stream plus error pulses
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport master (output rx_data, rx_valid, rx_frame_err, rx_overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, rx_frame_err, rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - generic two-flop synchronizer with configurable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two back-to-back flops resolve metastability on the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with one-deep output holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  rx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                 rxd_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 deliver;
    logic                 accept;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    // State, bit timing and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame sequencing: mid-bit sampling, false-start rejection, break recovery.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a full register only takes a new byte if it is drained the same cycle.
    always_comb begin
        accept    = valid_q & rx.rx_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver && (!valid_q || accept)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (deliver) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = frame_err_q;
    assign rx.rx_overrun   = overrun_q;
endmodule
